wave_analyzer_mc: RTL and testbench
===================================

Name: wave_analyzer_mc

Overview:
- Parametrised multi-channel successor to the single-channel low/high wave analyzers used in the equalizer bench.
- Measures per-channel period in clk cycles and peak magnitude of signed audio samples, e.g. PDM decoder lft/rght_inverse or FIR band outputs.
- Generalises the analyzers in three ways: channel count, sample/count widths, and hysteresis. It adds period averaging over 2^AVG_LOG2 cycles, timeout detection and per-channel clear.
- Sits in verification and self-test paths feeding pass/fail checks on filter band frequency and volume scaling.

Parameters:
CH, 2, number of independent channels
W, 16, signed sample width
PW, 22, period output width (cycles)
HYST, 64, zero-crossing hysteresis threshold (magnitude, same units as sample)
AVG_LOG2, 2, periods averaged per result = 2^AVG_LOG2
TIMEOUT, 4194303, max cycles between rising crossings before timeout (<= 2^PW-1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
smp_in  in  CH*W  packed signed samples; channel c at [c*W +: W]
smp_vld  in  1  sample strobe shared by all channels; crossing/peak logic updates only when high
clr  in  CH  per-channel synchronous clear
freq  out  CH*PW  averaged period in clk cycles per channel
amp  out  CH*W  unsigned peak magnitude over the last window per channel
vld  out  CH  one-cycle pulse per channel when freq/amp update
tmo  out  CH  sticky timeout flag per channel

Behaviour:
- Reset (rst_n low at posedge clk): freq=0, amp=0, vld=0, tmo=0, all channel FSMs enter ARM, all counters and accumulators cleared.
- Clock synchronous only. Channels are fully independent.
- Polarity tracker per channel, evaluated only on smp_vld:
  - pol goes to POS when sample > +HYST.
  - pol goes to NEG when sample < -HYST.
  - Otherwise pol holds.
  - Rising event = pol NEG->POS transition.
- Magnitude: |sample|, with -2^(W-1) saturating to 2^(W-1)-1.
- FSM per channel:
  - ARM: pol unknown. On the first threshold crossing in either direction, set pol and go to WAIT.
  - WAIT: on a rising event, zero cnt, sum, peak and nper, then go to MEAS.
  - MEAS:
    - cnt increments every clk, saturating at TIMEOUT.
    - On smp_vld, peak = max(peak, magnitude).
    - On a rising event: sum += cnt+1; nper++; cnt=0.
    - When nper reaches 2^AVG_LOG2:
      - Next cycle, freq = sum >> AVG_LOG2 (truncating) and amp = peak; vld pulses 1 cycle.
      - sum, peak and nper are cleared and the FSM stays in MEAS. The window restarts at this rising edge (back-to-back windows, no gap).
    - If cnt reaches TIMEOUT without a rising event:
      - freq = all ones, amp = peak, vld pulses, tmo set; go to ARM.
- sum width is PW+AVG_LOG2, so no overflow is possible given TIMEOUT <= 2^PW-1.
- Latency: vld is asserted exactly 1 clk after the smp_vld cycle carrying the completing rising event.
- clr[c]: the next cycle channel c is in ARM with freq=0, amp=0, tmo=0, vld=0 and internals cleared. clr wins over a simultaneous rising event, window completion or timeout.
- Reset or clr mid-window discards the partial window. No vld is issued for it.
- smp_vld low: cnt still counts clocks. pol and peak hold.
- Outputs hold their last value between vld pulses.

Test Plan:
- CH=2, ch0 square ±1000 with 500-cycle half period, smp_vld=1 -> first ch0 vld exactly 1 clk after the 5th rising event; freq=1000, amp=1000; subsequent vld every 4000 cycles.
- ch0 period 1000, ch1 period 250 simultaneously -> ch0 freq=1000, ch1 freq=250. vld pulses are independent, with ch1 pulsing 4x as often.
- ch0 ±50 noise around 0 with TIMEOUT=5000 -> no crossings detected (ARM stays), no vld, tmo=0. Then a single step to +1000 and hold -> WAIT entered, no MEAS, still no vld.
- ch0 periods 1000,1001,1002,1003 -> freq=1001 (4006>>2). A sample of -32768 inside the window -> amp=32767.
- Rising events stop mid-MEAS with TIMEOUT=5000 -> vld 5000 cycles after the last rising event; freq=4194303, tmo=1 and sticky. clr[0] -> freq=0, amp=0, tmo=0 next cycle.
- clr[1] asserted on the same cycle as ch1's completing rising event -> no ch1 vld and ch1 outputs zero, while ch0 is unaffected. rst_n low for one cycle mid-window -> all outputs 0; the next vld appears only after a full new window.

Source files
------------

// File: rtl/wave_analyzer_mc.sv
// Multi-channel wave analyzer: per-channel hysteretic zero-crossing period
// averaging, peak magnitude capture, timeout detection and synchronous clear.
module wave_analyzer_mc #(
  parameter int unsigned CH       = 2,
  parameter int unsigned W        = 16,
  parameter int unsigned PW       = 22,
  parameter int unsigned HYST     = 64,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 4194303
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH*W-1:0]   smp_in,
  input  logic              smp_vld,
  input  logic [CH-1:0]     clr,
  output logic [CH*PW-1:0]  freq,
  output logic [CH*W-1:0]   amp,
  output logic [CH-1:0]     vld,
  output logic [CH-1:0]     tmo
);

  localparam int unsigned SW = PW + AVG_LOG2;
  localparam int unsigned NW = AVG_LOG2 + 1;
  localparam logic signed [W-1:0] HYST_POS = W'(HYST);
  localparam logic signed [W-1:0] HYST_NEG = -HYST_POS;
  localparam logic [W-1:0]  SMP_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  MAG_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [PW-1:0] CNT_SAT   = PW'(TIMEOUT);
  localparam logic [PW-1:0] CNT_LAST  = PW'(TIMEOUT - 1);
  localparam logic [NW-1:0] NPER_LAST = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {S_ARM, S_WAIT, S_MEAS} state_e;
  typedef enum logic       {POL_NEG, POL_POS}      pol_e;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_e          state_q, state_d;
    pol_e            pol_q, pol_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [W-1:0]    peak_q, peak_d;
    logic [NW-1:0]   nper_q, nper_d;
    logic [PW-1:0]   freq_q, freq_d;
    logic [W-1:0]    amp_q, amp_d;
    logic            vld_q, vld_d;
    logic            tmo_q, tmo_d;

    logic [W-1:0]        raw;
    logic signed [W-1:0] smp;
    logic [W-1:0]        mag, peak_now;
    logic                above, below, rise, done, tout;
    logic [SW-1:0]       sum_nx;

    assign raw = smp_in[c*W +: W];
    assign smp = $signed(raw);

    always_comb begin
      if (!raw[W-1])           mag = raw;
      else if (raw == SMP_MIN) mag = MAG_MAX;
      else                     mag = ~raw + W'(1);
    end

    assign above    = smp_vld && (smp > HYST_POS);
    assign below    = smp_vld && (smp < HYST_NEG);
    assign rise     = above && (pol_q == POL_NEG) && (state_q != S_ARM);
    assign done     = (state_q == S_MEAS) && rise && (nper_q == NPER_LAST);
    // cnt_q holds elapsed-1, so TIMEOUT-1 here means a full TIMEOUT-cycle period passed
    assign tout     = (state_q == S_MEAS) && !rise && (cnt_q >= CNT_LAST);
    assign peak_now = (smp_vld && (mag > peak_q)) ? mag : peak_q;
    assign sum_nx   = sum_q + SW'(cnt_q) + SW'(1);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= S_ARM;
        pol_q   <= POL_NEG;
        cnt_q   <= '0;
        sum_q   <= '0;
        peak_q  <= '0;
        nper_q  <= '0;
        freq_q  <= '0;
        amp_q   <= '0;
        vld_q   <= 1'b0;
        tmo_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        pol_q   <= pol_d;
        cnt_q   <= cnt_d;
        sum_q   <= sum_d;
        peak_q  <= peak_d;
        nper_q  <= nper_d;
        freq_q  <= freq_d;
        amp_q   <= amp_d;
        vld_q   <= vld_d;
        tmo_q   <= tmo_d;
      end
    end

    always_comb begin
      state_d = state_q;
      unique case (state_q)
        S_ARM:   if (above || below) state_d = S_WAIT;
        S_WAIT:  if (rise) state_d = S_MEAS;
        S_MEAS:  if (tout) state_d = S_ARM;
        default: state_d = S_ARM;
      endcase
      if (clr[c]) state_d = S_ARM;
    end

    always_comb begin
      pol_d  = above ? POL_POS : (below ? POL_NEG : pol_q);
      cnt_d  = cnt_q;
      sum_d  = sum_q;
      peak_d = peak_q;
      nper_d = nper_q;
      freq_d = freq_q;
      amp_d  = amp_q;
      vld_d  = 1'b0;
      tmo_d  = tmo_q;
      case (state_q)
        S_WAIT: begin
          if (rise) begin
            cnt_d  = '0;
            sum_d  = '0;
            peak_d = '0;
            nper_d = '0;
          end
        end
        S_MEAS: begin
          cnt_d  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + PW'(1);
          peak_d = peak_now;
          if (done) begin
            freq_d = PW'(sum_nx >> AVG_LOG2);
            amp_d  = peak_now;
            vld_d  = 1'b1;
            cnt_d  = '0;
            sum_d  = '0;
            peak_d = '0;
            nper_d = '0;
          end else if (rise) begin
            sum_d  = sum_nx;
            nper_d = nper_q + NW'(1);
            cnt_d  = '0;
          end else if (tout) begin
            freq_d = '1;
            amp_d  = peak_now;
            vld_d  = 1'b1;
            tmo_d  = 1'b1;
            cnt_d  = '0;
            sum_d  = '0;
            peak_d = '0;
            nper_d = '0;
          end
        end
        default: ;
      endcase
      if (clr[c]) begin
        pol_d  = POL_NEG;
        cnt_d  = '0;
        sum_d  = '0;
        peak_d = '0;
        nper_d = '0;
        freq_d = '0;
        amp_d  = '0;
        vld_d  = 1'b0;
        tmo_d  = 1'b0;
      end
    end

    assign freq[c*PW +: PW] = freq_q;
    assign amp[c*W +: W]    = amp_q;
    assign vld[c]           = vld_q;
    assign tmo[c]           = tmo_q;
  end

endmodule

// File: tb/tb_wave_analyzer_mc.sv
// Bench for wave_analyzer_mc: event-level reference model checked every cycle,
// a scenario table of square waves, and hand sequences for the corner cases.
module tb_wave_analyzer_mc;

  localparam int CH  = 2;
  localparam int W   = 16;
  localparam int PW  = 22;
  localparam int HY  = 64;
  localparam int AVG = 2;
  localparam int TO  = 5000;
  localparam int NAV = 1 << AVG;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*W-1:0]   smp_in;
  logic              smp_vld;
  logic [CH-1:0]     clr;
  logic [CH*PW-1:0]  freq;
  logic [CH*W-1:0]   amp;
  logic [CH-1:0]     vld;
  logic [CH-1:0]     tmo;

  always #5 clk = ~clk;

  wave_analyzer_mc #(
    .CH(CH), .W(W), .PW(PW), .HYST(HY), .AVG_LOG2(AVG), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .smp_in(smp_in), .smp_vld(smp_vld), .clr(clr),
    .freq(freq), .amp(amp), .vld(vld), .tmo(tmo)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: mode 0 = armed, 1 = waiting for first rise, 2 = measuring.
  longint cyc = 0;
  int     m_mode[CH];
  int     m_pol[CH];
  longint m_tlast[CH];
  int     m_per[CH][NAV];
  int     m_np[CH];
  int     m_peak[CH];
  int     e_freq[CH];
  int     e_amp[CH];
  bit     e_vld[CH];
  bit     e_tmo[CH];

  int g_kind[CH];
  int g_half[CH];
  int g_amp[CH];
  int g_ph[CH];
  int g_rem[CH];
  int g_lvl[CH];
  bit g_rvld = 1'b0;
  int vcnt[CH];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    logic signed [W-1:0] sv;
    int  x, mg, s;
    bit  up, dn, rise;
    cyc++;
    for (int unsigned c = 0; c < CH; c++) begin
      e_vld[c] = 1'b0;
      if (!rst_n || clr[c]) begin
        m_mode[c] = 0; m_pol[c] = 0; m_np[c] = 0; m_peak[c] = 0;
        e_freq[c] = 0; e_amp[c] = 0; e_tmo[c] = 1'b0;
        continue;
      end
      sv = smp_in[c*W +: W];
      x  = sv;
      mg = (x < 0) ? -x : x;
      if (mg > 32767) mg = 32767;
      up   = smp_vld && (x > HY);
      dn   = smp_vld && (x < -HY);
      rise = (m_mode[c] != 0) && (m_pol[c] == -1) && up;
      case (m_mode[c])
        0: if (up || dn) m_mode[c] = 1;
        1: if (rise) begin
             m_mode[c] = 2; m_tlast[c] = cyc; m_np[c] = 0; m_peak[c] = 0;
           end
        default: begin
          if (smp_vld && mg > m_peak[c]) m_peak[c] = mg;
          if (rise) begin
            m_per[c][m_np[c]] = int'(cyc - m_tlast[c]);
            m_np[c]++;
            m_tlast[c] = cyc;
            if (m_np[c] == NAV) begin
              s = 0;
              for (int unsigned k = 0; k < NAV; k++) s += m_per[c][k];
              e_freq[c] = s / NAV;
              e_amp[c]  = m_peak[c];
              e_vld[c]  = 1'b1;
              m_np[c]   = 0;
              m_peak[c] = 0;
            end
          end else if (cyc - m_tlast[c] >= TO) begin
            e_freq[c] = (1 << PW) - 1;
            e_amp[c]  = m_peak[c];
            e_vld[c]  = 1'b1;
            e_tmo[c]  = 1'b1;
            m_mode[c] = 0;
          end
        end
      endcase
      if (up) m_pol[c] = 1;
      else if (dn) m_pol[c] = -1;
    end
  endtask

  task automatic check_cycle();
    logic [CH*PW-1:0] ef;
    logic [CH*W-1:0]  ea;
    logic [CH-1:0]    ev, et;
    for (int unsigned c = 0; c < CH; c++) begin
      ef[c*PW +: PW] = PW'(e_freq[c]);
      ea[c*W +: W]   = W'(e_amp[c]);
      ev[c] = e_vld[c];
      et[c] = e_tmo[c];
    end
    check($sformatf("model_cycle%0d", cyc), 128'({freq, amp, vld, tmo}), 128'({ef, ea, ev, et}));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_cycle();
    for (int unsigned c = 0; c < CH; c++) if (vld[c]) vcnt[c]++;
  endtask

  task automatic pick(input int unsigned c);
    int mg;
    g_rem[c] = ($urandom_range(19) == 0) ? int'($urandom_range(5400, 5100))
                                         : int'($urandom_range(300, 10));
    mg = ($urandom_range(7) == 0) ? int'($urandom_range(100)) : int'($urandom_range(32767));
    g_lvl[c] = (g_lvl[c] > 0) ? -mg : mg;
    if ($urandom_range(19) == 0) g_lvl[c] = -32768;
  endtask

  task automatic run(input int unsigned n);
    int v;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned c = 0; c < CH; c++) begin
        case (g_kind[c])
          1: begin
            v = (g_ph[c] < g_half[c]) ? -g_amp[c] : g_amp[c];
            g_ph[c] = (g_ph[c] + 1) % (2 * g_half[c]);
          end
          2: v = int'($urandom_range(100)) - 50;
          3: begin
            if (g_rem[c] == 0) pick(c);
            g_rem[c]--;
            v = g_lvl[c];
          end
          default: v = g_lvl[c];
        endcase
        smp_in[c*W +: W] = W'(v);
        if (g_rvld) clr[c] = ($urandom_range(999) == 0);
      end
      if (g_rvld) smp_vld = ($urandom_range(9) != 0);
      step();
    end
  endtask

  task automatic hold(input int v0, input int v1, input int unsigned n);
    g_kind[0] = 0; g_lvl[0] = v0;
    g_kind[1] = 0; g_lvl[1] = v1;
    run(n);
  endtask

  task automatic square(input int h0, input int a0, input int h1, input int a1);
    g_kind[0] = 1; g_half[0] = h0; g_amp[0] = a0; g_ph[0] = 0;
    g_kind[1] = 1; g_half[1] = h1; g_amp[1] = a1; g_ph[1] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hold(0, 0, 2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int h0, a0, h1, a1, n;
    int f0, am0, f1, am1, nv0, nv1;
  } vec_t;

  vec_t tbl[3];
  int   s0, s1;

  initial begin
    rst_n = 1'b0; smp_vld = 1'b1; clr = '0; smp_in = '0;
    tbl[0] = '{500, 1000,  125, 3000, 8600, 1000, 1000,  250, 3000, 2, 8};
    tbl[1] = '{300, 20000, 700, 65,   9000, 600,  20000, 1400, 65,  3, 1};
    tbl[2] = '{50,  32767, 100, 64,   1000, 100,  32767, 0,    0,   2, 0};

    for (int unsigned i = 0; i < 3; i++) begin
      do_reset();
      check($sformatf("reset_row%0d", i), 128'({freq, amp, vld, tmo}), 128'(0));
      square(tbl[i].h0, tbl[i].a0, tbl[i].h1, tbl[i].a1);
      s0 = vcnt[0]; s1 = vcnt[1];
      run(tbl[i].n);
      check($sformatf("row%0d_freq0", i), 128'(freq[PW-1:0]),    128'(tbl[i].f0));
      check($sformatf("row%0d_amp0", i),  128'(amp[W-1:0]),      128'(tbl[i].am0));
      check($sformatf("row%0d_freq1", i), 128'(freq[2*PW-1:PW]), 128'(tbl[i].f1));
      check($sformatf("row%0d_amp1", i),  128'(amp[2*W-1:W]),    128'(tbl[i].am1));
      check($sformatf("row%0d_nvld0", i), 128'(vcnt[0] - s0),    128'(tbl[i].nv0));
      check($sformatf("row%0d_nvld1", i), 128'(vcnt[1] - s1),    128'(tbl[i].nv1));
    end

    // Sub-hysteresis noise never arms; a lone step only reaches WAIT.
    do_reset();
    g_kind[0] = 2; g_kind[1] = 0; g_lvl[1] = 0;
    s0 = vcnt[0];
    run(3000);
    check("noise_nvld", 128'(vcnt[0] - s0), 128'(0));
    check("noise_out0", 128'({freq[PW-1:0], amp[W-1:0], tmo[0]}), 128'(0));
    hold(1000, 0, 6000);
    check("step_nvld", 128'(vcnt[0] - s0), 128'(0));
    check("step_tmo0", 128'(tmo[0]), 128'(0));

    // Periods 1000..1003 with a full-scale negative sample.
    do_reset();
    hold(-1000, 0, 500);
    hold(1000, 0, 500);
    for (int p = 1000; p <= 1003; p++) begin
      if (p == 1000) begin
        hold(-1000, 0, 100);
        hold(-32768, 0, 1);
        hold(-1000, 0, p - 601);
      end else begin
        hold(-1000, 0, p - 500);
      end
      if (p == 1003) hold(1000, 0, 1);
      else hold(1000, 0, 500);
    end
    check("avg_vld0",  128'(vld[0]),        128'(1));
    check("avg_freq0", 128'(freq[PW-1:0]),  128'(1001));
    check("avg_amp0",  128'(amp[W-1:0]),    128'(32767));

    // Rising events stop: timeout after TO cycles, sticky, then clear.
    hold(1000, 0, TO - 1);
    check("pre_tmo", 128'({vld[0], tmo[0]}), 128'(0));
    hold(1000, 0, 1);
    check("tmo_vld0",  128'(vld[0]),       128'(1));
    check("tmo_freq0", 128'(freq[PW-1:0]), 128'((1 << PW) - 1));
    check("tmo_amp0",  128'(amp[W-1:0]),   128'(1000));
    check("tmo_flag0", 128'(tmo[0]),       128'(1));
    hold(1000, 0, 10);
    check("tmo_sticky", 128'({vld[0], tmo[0]}), 128'(1));
    clr = 2'b01;
    hold(1000, 0, 1);
    clr = '0;
    check("clr0_out", 128'({freq[PW-1:0], amp[W-1:0], vld[0], tmo[0]}), 128'(0));

    // clr[1] on ch1's completing rise; ch0 keeps measuring.
    do_reset();
    square(500, 1000, 125, 2000);
    run(2125);
    check("pre_clr_freq1", 128'(freq[2*PW-1:PW]), 128'(250));
    check("pre_clr_amp1",  128'(amp[2*W-1:W]),    128'(2000));
    clr = 2'b10;
    run(1);
    clr = '0;
    check("clr1_out", 128'({freq[2*PW-1:PW], amp[2*W-1:W], vld[1], tmo[1]}), 128'(0));
    run(2375);
    check("ch0_indep_vld",  128'(vld[0]),       128'(1));
    check("ch0_indep_freq", 128'(freq[PW-1:0]), 128'(1000));

    // Reset mid-window discards it; next result needs a full new window.
    run(1500);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    check("midrst_out", 128'({freq, amp, vld, tmo}), 128'(0));
    s0 = vcnt[0];
    run(3500);
    check("postrst_none", 128'(vcnt[0] - s0), 128'(0));
    run(2000);
    check("postrst_one", 128'(vcnt[0] - s0), 128'(1));

    // Randomised levels, strobe gaps and clears against the model.
    do_reset();
    g_kind[0] = 3; g_kind[1] = 3; g_rem[0] = 0; g_rem[1] = 0;
    g_rvld = 1'b1;
    run(15000);
    g_rvld = 1'b0; smp_vld = 1'b1; clr = '0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
